// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode/forwarding enums and the ID/EX entry record
// for the 16-bit CPU core.
//   DATA_W  operand/result width
//   REG_AW  register index width (r0 reads as zero)
//   OP_W    ALU opcode width
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_NOP = 4'b0000,
    ALU_ADD = 4'b0001
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // One held instruction as presented to the execute stage.
  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } id_ex_entry_t;

  // Saturating 16-bit increment used by the event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'h0001);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// fwd_unit: combinational operand forwarding selector for one source index.
// Ports:
//   rs_i                      source register index
//   rf_data_i                 register-file read data for rs_i
//   exmem_reg_write_i/_rd_i/_result_i   EX/MEM writer (highest priority)
//   memwb_reg_write_i/_rd_i/_result_i   MEM/WB writer
//   sel_o                     chosen source
//   val_o                     chosen value (zero for r0)
module fwd_unit
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output fwd_sel_t          sel_o,
  output logic [DATA_W-1:0] val_o
);

  // Priority select: r0 is constant zero, then EX/MEM, then MEM/WB, then RF.
  always_comb begin
    sel_o = FWD_RF;
    val_o = rf_data_i;
    if (rs_i == {REG_AW{1'b0}}) begin
      sel_o = FWD_RF;
      val_o = {DATA_W{1'b0}};
    end else if (exmem_reg_write_i && (exmem_rd_i == rs_i)) begin
      sel_o = FWD_EXMEM;
      val_o = exmem_result_i;
    end else if (memwb_reg_write_i && (memwb_rd_i == rs_i)) begin
      sel_o = FWD_MEMWB;
      val_o = memwb_result_i;
    end else begin
      sel_o = FWD_RF;
      val_o = rf_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register. Captures decoded control,
// resolves rs1/rs2 forwarding from EX/MEM and MEM/WB, inserts one bubble on a
// load-use hazard, and supports flush plus valid/ready on both sides.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               decode-side handshake
//   in_alu_op, in_rs1/2, in_rd, in_rd1/2_data, in_imm, in_use_imm,
//   in_reg_write/mem_read/mem_write decoded instruction
//   flush                           kill held and incoming instruction
//   exmem_*, memwb_*                forwarding sources
//   out_valid/out_ready             execute-side handshake
//   out_alu_op, out_src_a/b, out_store_data, out_rd, out_* control
//   load_use_stall                  bubble being inserted this cycle
// Optional macro ID_EX_PERF_CNT_EN adds saturating perf_stall_cnt and
// perf_flush_cnt outputs.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_alu_op,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_rd1_data,
  input  logic [DATA_W-1:0] in_rd2_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_alu_op,
  output logic [DATA_W-1:0] out_src_a,
  output logic [DATA_W-1:0] out_src_b,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              load_use_stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  id_ex_entry_t      entry_q, entry_d;
  fwd_sel_t          rs1_sel_s, rs2_sel_s;
  logic [DATA_W-1:0] fwd1_s, fwd2_s, rs1_val_s, rs2_val_s;
  logic              stall_s, ready_s, capture_s;

  fwd_unit u_fwd_rs1 (
    .rs_i(in_rs1), .rf_data_i(in_rd1_data),
    .exmem_reg_write_i(exmem_reg_write), .exmem_rd_i(exmem_rd), .exmem_result_i(exmem_result),
    .memwb_reg_write_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .memwb_result_i(memwb_result),
    .sel_o(rs1_sel_s), .val_o(fwd1_s)
  );

  fwd_unit u_fwd_rs2 (
    .rs_i(in_rs2), .rf_data_i(in_rd2_data),
    .exmem_reg_write_i(exmem_reg_write), .exmem_rd_i(exmem_rd), .exmem_result_i(exmem_result),
    .memwb_reg_write_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .memwb_result_i(memwb_result),
    .sel_o(rs2_sel_s), .val_o(fwd2_s)
  );

  // Operand muxes driven by the selector decisions; the RF leg already carries
  // the r0-as-zero value from the unit.
  always_comb begin
    rs1_val_s = fwd1_s;
    rs2_val_s = fwd2_s;
    case (rs1_sel_s)
      FWD_EXMEM: rs1_val_s = exmem_result;
      FWD_MEMWB: rs1_val_s = memwb_result;
      FWD_RF:    rs1_val_s = fwd1_s;
      default:   rs1_val_s = fwd1_s;
    endcase
    case (rs2_sel_s)
      FWD_EXMEM: rs2_val_s = exmem_result;
      FWD_MEMWB: rs2_val_s = memwb_result;
      FWD_RF:    rs2_val_s = fwd2_s;
      default:   rs2_val_s = fwd2_s;
    endcase
  end

  // A held load whose destination feeds the incoming instruction: rs2 only
  // matters when it is a real ALU source or the store data.
  assign stall_s = entry_q.valid & entry_q.mem_read & entry_q.reg_write &
                   (entry_q.rd != {REG_AW{1'b0}}) & in_valid &
                   ((entry_q.rd == in_rs1) |
                    ((entry_q.rd == in_rs2) & (~in_use_imm | in_mem_write)));

  // Flush always accepts so decode can drop the instruction it is presenting.
  assign ready_s   = flush | (~stall_s & (~entry_q.valid | out_ready));
  assign capture_s = in_valid & ready_s & ~flush;

  // Next entry: flush kills, capture loads, consumption (including the
  // stall-with-ready case) leaves an all-zero bubble, otherwise hold.
  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d = '0;
    end else if (capture_s) begin
      entry_d.valid      = 1'b1;
      entry_d.alu_op     = in_alu_op;
      entry_d.src_a      = rs1_val_s;
      entry_d.src_b      = in_use_imm ? in_imm : rs2_val_s;
      entry_d.store_data = rs2_val_s;
      entry_d.rd         = in_rd;
      entry_d.reg_write  = in_reg_write;
      entry_d.mem_read   = in_mem_read;
      entry_d.mem_write  = in_mem_write;
    end else if (out_ready) begin
      entry_d = '0;
    end else begin
      entry_d = entry_q;
    end
  end

  // Pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign in_ready       = ready_s;
  assign load_use_stall = stall_s;
  assign out_valid      = entry_q.valid;
  assign out_alu_op     = entry_q.alu_op;
  assign out_src_a      = entry_q.src_a;
  assign out_src_b      = entry_q.src_b;
  assign out_store_data = entry_q.store_data;
  assign out_rd         = entry_q.rd;
  assign out_reg_write  = entry_q.reg_write;
  assign out_mem_read   = entry_q.mem_read;
  assign out_mem_write  = entry_q.mem_write;

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall/flush event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (stall_s) stall_cnt_q <= sat_inc16(stall_cnt_q);
      if (flush)   flush_cnt_q <= sat_inc16(flush_cnt_q);
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
